// File: rtl/dcache_bank_pkg.sv
// Shared types for the data-cache bank arbiter and its store buffer.
// Optional feature macro: DCACHE_SB_FWD_EN (full-word store-to-load forwarding).
package dcache_bank_pkg;

  localparam int unsigned LINE_WORDS  = 8;
  // Widest word address a store-buffer entry can carry; narrower addresses
  // are zero-extended into it.
  localparam int unsigned SB_ADDR_MAX = 16;

  typedef struct packed {
    logic [SB_ADDR_MAX-1:0] addr;
    logic [3:0]             ben;
    logic [31:0]            data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_LOAD,
    OP_DRAIN,
    OP_REFILL
  } bank_op_e;

endpackage

// File: rtl/dcache_store_buf.sv
// Store buffer FIFO for one data-cache bank: push/pop storage, per-entry
// word and line match vectors, and youngest full-word forward data.
// Optional feature macro: DCACHE_SB_FWD_EN (forward path; tied off otherwise).
module dcache_store_buf
  import dcache_bank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned SB_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH-1:0] i_push_addr,
  input  logic [3:0]            i_push_ben,
  input  logic [31:0]           i_push_data,
  input  logic                  i_pop,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [ADDR_WIDTH-1:0] i_rf_addr,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH-1:0] o_head_addr,
  output logic [3:0]            o_head_ben,
  output logic [31:0]           o_head_data,
  output logic [SB_DEPTH-1:0]   o_word_match,
  output logic [SB_DEPTH-1:0]   o_line_match,
  output logic                  o_fwd_hit,
  output logic [31:0]           o_fwd_data
);

  localparam int unsigned PTR_W   = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned LINE_SH = $clog2(LINE_WORDS);

  sb_entry_t              r_mem [SB_DEPTH];
  logic [PTR_W-1:0]       r_wr;
  logic [PTR_W-1:0]       r_rd;
  logic [CNT_W-1:0]       r_count;
  sb_entry_t              w_push_entry;
  logic [SB_ADDR_MAX-1:0] w_ld_key;
  logic [SB_ADDR_MAX-1:0] w_rf_key;
  logic [PTR_W-1:0]       w_idx;
`ifdef DCACHE_SB_FWD_EN
  logic                   w_fwd_any;
  logic [3:0]             w_fwd_ben;
  logic [31:0]            w_fwd_data;
`endif

  assign w_ld_key = SB_ADDR_MAX'(i_ld_addr);
  assign w_rf_key = SB_ADDR_MAX'(i_rf_addr);

  // Assemble the entry written on push
  always_comb begin
    w_push_entry      = '0;
    w_push_entry.addr = SB_ADDR_MAX'(i_push_addr);
    w_push_entry.ben  = i_push_ben;
    w_push_entry.data = i_push_data;
  end

  // Pointer and occupancy update; pointers wrap naturally at SB_DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the slot is unoccupied
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= w_push_entry;
  end

  assign o_full      = (r_count == CNT_W'(SB_DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_addr = r_mem[r_rd].addr[ADDR_WIDTH-1:0];
  assign o_head_ben  = r_mem[r_rd].ben;
  assign o_head_data = r_mem[r_rd].data;

  // Walk occupied entries oldest to youngest so the last word match seen
  // is the youngest one, which is the only one allowed to forward.
  always_comb begin
    o_word_match = '0;
    o_line_match = '0;
    w_idx        = '0;
`ifdef DCACHE_SB_FWD_EN
    w_fwd_any    = 1'b0;
    w_fwd_ben    = '0;
    w_fwd_data   = '0;
`endif
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      w_idx = r_rd + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if (r_mem[w_idx].addr == w_ld_key) begin
          o_word_match[w_idx] = 1'b1;
`ifdef DCACHE_SB_FWD_EN
          w_fwd_any  = 1'b1;
          w_fwd_ben  = r_mem[w_idx].ben;
          w_fwd_data = r_mem[w_idx].data;
`endif
        end
        if ((r_mem[w_idx].addr >> LINE_SH) == (w_rf_key >> LINE_SH))
          o_line_match[w_idx] = 1'b1;
      end
    end
  end

`ifdef DCACHE_SB_FWD_EN
  assign o_fwd_hit  = w_fwd_any && (w_fwd_ben == 4'hF);
  assign o_fwd_data = w_fwd_data;
`else
  assign o_fwd_hit  = 1'b0;
  assign o_fwd_data = '0;
`endif

endmodule

// File: rtl/dcache_bank_arbiter.sv
// Arbiter/sequencer for one data-cache bank: chooses one of refill, store
// drain or load each cycle and returns load data one cycle after accept.
// Optional feature macro: DCACHE_SB_FWD_EN (handled inside dcache_store_buf;
// with it undefined the forward hit is constant 0 and every match blocks).
module dcache_bank_arbiter
  import dcache_bank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned SB_DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_WIDTH-1:0]    ld_addr,
  output logic                     ld_rvalid,
  output logic [31:0]              ld_rdata,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_WIDTH-1:0]    st_addr,
  input  logic [3:0]               st_ben,
  input  logic [31:0]              st_data,
  input  logic                     rf_valid,
  output logic                     rf_ready,
  input  logic [ADDR_WIDTH-1:0]    rf_addr,
  input  logic [32*LINE_WORDS-1:0] rf_line,
  output logic                     sb_empty,
  output logic [ADDR_WIDTH-1:0]    bank_raddr,
  output logic [ADDR_WIDTH-1:0]    bank_waddr,
  output logic                     bank_re,
  output logic                     bank_we,
  output logic                     bank_store,
  output logic                     bank_hit_write,
  output logic [3:0]               bank_byte_ben,
  output logic [31:0]              bank_din,
  output logic [32*LINE_WORDS-1:0] bank_din_all,
  input  logic [31:0]              bank_dout
);

  bank_op_e              w_op;
  logic                  w_full;
  logic                  w_empty;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [3:0]            w_head_ben;
  logic [31:0]           w_head_data;
  logic [SB_DEPTH-1:0]   w_word_match;
  logic [SB_DEPTH-1:0]   w_line_match;
  logic                  w_fwd_hit;
  logic [31:0]           w_fwd_data;
  logic                  w_ld_block;
  logic                  w_rf_block;
  logic                  w_push;
  logic                  w_pop;
  logic                  r_rvalid;
  logic                  r_fwd_sel;
  logic [31:0]           r_fwd_data;
  logic [ADDR_WIDTH-1:0] r_raddr;

  // Stores are accepted purely on registered occupancy, never bypassing
  // the buffer; a store and a load to the same word in one cycle see the
  // load first because the new entry is only visible next cycle.
  assign st_ready = !w_full;
  assign sb_empty = w_empty;
  assign w_push   = st_valid && !w_full;
  assign w_pop    = (w_op == OP_DRAIN);

  dcache_store_buf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .SB_DEPTH   (SB_DEPTH)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_addr  (st_addr),
    .i_push_ben   (st_ben),
    .i_push_data  (st_data),
    .i_pop        (w_pop),
    .i_ld_addr    (ld_addr),
    .i_rf_addr    (rf_addr),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_head_addr  (w_head_addr),
    .o_head_ben   (w_head_ben),
    .o_head_data  (w_head_data),
    .o_word_match (w_word_match),
    .o_line_match (w_line_match),
    .o_fwd_hit    (w_fwd_hit),
    .o_fwd_data   (w_fwd_data)
  );

  assign w_ld_block = (|w_word_match) && !w_fwd_hit;
  assign w_rf_block = |w_line_match;

  // Per-cycle bank operation select, highest priority first
  always_comb begin
    w_op = OP_IDLE;
    if (rf_valid && !w_rf_block)
      w_op = OP_REFILL;
    else if (w_full || (rf_valid && w_rf_block) || (ld_valid && w_ld_block))
      w_op = OP_DRAIN;
    else if (ld_valid)
      w_op = OP_LOAD;
    else if (!w_empty)
      w_op = OP_DRAIN;
  end

  assign ld_ready = (w_op == OP_LOAD);
  assign rf_ready = (w_op == OP_REFILL);

  // Bank port drive for the selected operation
  always_comb begin
    bank_re        = 1'b0;
    bank_we        = 1'b0;
    bank_store     = 1'b0;
    bank_hit_write = 1'b0;
    bank_waddr     = '0;
    bank_byte_ben  = '0;
    bank_din       = '0;
    bank_din_all   = '0;
    bank_raddr     = r_raddr;
    case (w_op)
      OP_REFILL: begin
        bank_we        = 1'b1;
        bank_hit_write = 1'b1;
        bank_waddr     = rf_addr;
        bank_din_all   = rf_line;
      end
      OP_DRAIN: begin
        bank_we       = 1'b1;
        bank_store    = 1'b1;
        bank_waddr    = w_head_addr;
        bank_byte_ben = w_head_ben;
        bank_din      = w_head_data;
      end
      OP_LOAD: begin
        bank_re    = !w_fwd_hit;
        bank_raddr = ld_addr;
      end
      default: ;
    endcase
  end

  // Load return pipeline and held read address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid   <= 1'b0;
      r_fwd_sel  <= 1'b0;
      r_fwd_data <= '0;
      r_raddr    <= '0;
    end else begin
      r_rvalid  <= (w_op == OP_LOAD);
      r_fwd_sel <= (w_op == OP_LOAD) && w_fwd_hit;
      if ((w_op == OP_LOAD) && w_fwd_hit) r_fwd_data <= w_fwd_data;
      if (w_op == OP_LOAD) r_raddr <= ld_addr;
    end
  end

  assign ld_rvalid = r_rvalid;
  assign ld_rdata  = r_rvalid ? (r_fwd_sel ? r_fwd_data : bank_dout) : '0;

endmodule

// File: tb/tb_dcache_bank_arbiter.sv
// Directed bench for dcache_bank_arbiter with a behavioural bank RAM.
// Optional feature macro: DCACHE_SB_FWD_EN selects forward-path expectations.
module tb_dcache_bank_arbiter;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid, ld_ready, ld_rvalid;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_rdata;
  logic          st_valid, st_ready;
  logic [AW-1:0] st_addr;
  logic [3:0]    st_ben;
  logic [31:0]   st_data;
  logic          rf_valid, rf_ready;
  logic [AW-1:0] rf_addr;
  logic [255:0]  rf_line;
  logic          sb_empty;
  logic [AW-1:0] bank_raddr, bank_waddr;
  logic          bank_re, bank_we, bank_store, bank_hit_write;
  logic [3:0]    bank_byte_ben;
  logic [31:0]   bank_din;
  logic [255:0]  bank_din_all;
  logic [31:0]   bank_dout;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_mem [1024];
  logic [255:0] line_pat;

  always #5 clk = ~clk;

  dcache_bank_arbiter #(
    .ADDR_WIDTH (AW),
    .SB_DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_rvalid      (ld_rvalid),
    .ld_rdata       (ld_rdata),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_addr        (st_addr),
    .st_ben         (st_ben),
    .st_data        (st_data),
    .rf_valid       (rf_valid),
    .rf_ready       (rf_ready),
    .rf_addr        (rf_addr),
    .rf_line        (rf_line),
    .sb_empty       (sb_empty),
    .bank_raddr     (bank_raddr),
    .bank_waddr     (bank_waddr),
    .bank_re        (bank_re),
    .bank_we        (bank_we),
    .bank_store     (bank_store),
    .bank_hit_write (bank_hit_write),
    .bank_byte_ben  (bank_byte_ben),
    .bank_din       (bank_din),
    .bank_din_all   (bank_din_all),
    .bank_dout      (bank_dout)
  );

  // Behavioural bank: byte-merged store, full-line refill, registered read
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) m_mem[i] <= 32'h0;
      m_mem[19] <= 32'hDEADBEEF;
      bank_dout <= 32'h0;
    end else begin
      if (bank_we && bank_store)
        for (int b = 0; b < 4; b++)
          if (bank_byte_ben[b]) m_mem[bank_waddr][8*b +: 8] <= bank_din[8*b +: 8];
      if (bank_we && bank_hit_write)
        for (int w = 0; w < 8; w++)
          m_mem[{bank_waddr[AW-1:3], 3'(w)}] <= bank_din_all[32*w +: 32];
      if (bank_re) bank_dout <= m_mem[bank_raddr];
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ld_valid = 1'b0; ld_addr = '0;
    st_valid = 1'b0; st_addr = '0; st_ben = '0; st_data = '0;
    rf_valid = 1'b0; rf_addr = '0; rf_line = '0;
    for (int w = 0; w < 8; w++) line_pat[32*w +: 32] = 32'hA0000000 | 32'(w);

    // Reset state
    @(negedge clk);
    chk("rst_rvalid",   256'(ld_rvalid), 256'(0));
    chk("rst_sb_empty", 256'(sb_empty),  256'(1));
    chk("rst_st_ready", 256'(st_ready),  256'(1));
    chk("rst_we",       256'(bank_we),   256'(0));
    chk("rst_re",       256'(bank_re),   256'(0));
    chk("rst_ld_ready", 256'(ld_ready),  256'(0));
    tick;
    rst = 1'b0;

    // Plain load from the bank
    ld_valid = 1'b1; ld_addr = 10'h013;
    @(negedge clk);
    chk("ld_re",    256'(bank_re),    256'(1));
    chk("ld_ready", 256'(ld_ready),   256'(1));
    chk("ld_raddr", 256'(bank_raddr), 256'(10'h013));
    tick;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("ld_rvalid", 256'(ld_rvalid), 256'(1));
    chk("ld_rdata",  256'(ld_rdata),  256'(32'hDEADBEEF));
    tick;
    @(negedge clk);
    chk("ld_rvalid_pulse", 256'(ld_rvalid),  256'(0));
    chk("raddr_hold",      256'(bank_raddr), 256'(10'h013));

    // Partial store blocks the following load until drained
    st_valid = 1'b1; st_addr = 10'h013; st_ben = 4'h3; st_data = 32'h0000AAAA;
    @(negedge clk);
    chk("st_ready_empty", 256'(st_ready), 256'(1));
    tick;
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 10'h013;
    @(negedge clk);
    chk("blk_ld_ready", 256'(ld_ready),      256'(0));
    chk("blk_store",    256'(bank_store),    256'(1));
    chk("blk_waddr",    256'(bank_waddr),    256'(10'h013));
    chk("blk_ben",      256'(bank_byte_ben), 256'(4'h3));
    chk("blk_din",      256'(bank_din),      256'(32'h0000AAAA));
    chk("blk_re",       256'(bank_re),       256'(0));
    tick;
    @(negedge clk);
    chk("unblk_ld_ready", 256'(ld_ready), 256'(1));
    chk("unblk_sb_empty", 256'(sb_empty), 256'(1));
    tick;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("merge_rvalid", 256'(ld_rvalid), 256'(1));
    chk("merge_rdata",  256'(ld_rdata),  256'(32'hDEADAAAA));
    tick;

    // Full-word store followed by a load to the same word
    st_valid = 1'b1; st_addr = 10'h013; st_ben = 4'hF; st_data = 32'h0000AAAA;
    tick;
    st_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 10'h013;
`ifdef DCACHE_SB_FWD_EN
    @(negedge clk);
    chk("fwd_ld_ready", 256'(ld_ready), 256'(1));
    chk("fwd_re",       256'(bank_re),  256'(0));
    tick;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("fwd_rvalid", 256'(ld_rvalid),  256'(1));
    chk("fwd_rdata",  256'(ld_rdata),   256'(32'h0000AAAA));
    chk("fwd_drain",  256'(bank_store), 256'(1));
`else
    @(negedge clk);
    chk("full_blk_ready", 256'(ld_ready),   256'(0));
    chk("full_blk_store", 256'(bank_store), 256'(1));
    tick;
    @(negedge clk);
    chk("full_ld_ready", 256'(ld_ready), 256'(1));
    chk("full_ld_re",    256'(bank_re),  256'(1));
    tick;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("full_rvalid", 256'(ld_rvalid), 256'(1));
    chk("full_rdata",  256'(ld_rdata),  256'(32'h0000AAAA));
`endif
    tick;
    @(negedge clk);
    chk("fwd_sb_empty", 256'(sb_empty), 256'(1));

    // Refill held off by a store to the same line
    st_valid = 1'b1; st_addr = 10'h02A; st_ben = 4'hF; st_data = 32'h11111111;
    tick;
    st_valid = 1'b0;
    rf_valid = 1'b1; rf_addr = 10'h028; rf_line = line_pat;
    @(negedge clk);
    chk("rf_wait_ready", 256'(rf_ready),       256'(0));
    chk("rf_wait_store", 256'(bank_store),     256'(1));
    chk("rf_wait_waddr", 256'(bank_waddr),     256'(10'h02A));
    chk("rf_wait_hw",    256'(bank_hit_write), 256'(0));
    tick;
    @(negedge clk);
    chk("rf_ready", 256'(rf_ready),       256'(1));
    chk("rf_hw",    256'(bank_hit_write), 256'(1));
    chk("rf_we",    256'(bank_we),        256'(1));
    chk("rf_line",  bank_din_all,         line_pat);
    chk("rf_waddr", 256'(bank_waddr),     256'(10'h028));
    chk("rf_store", 256'(bank_store),     256'(0));
    tick;
    rf_valid = 1'b0;
    ld_valid = 1'b1; ld_addr = 10'h02A;
    @(negedge clk);
    chk("rf_ld_ready", 256'(ld_ready), 256'(1));
    tick;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("rf_ld_rdata", 256'(ld_rdata), 256'(32'hA0000002));
    tick;

    // Stores fill the buffer under a continuous load stream
    st_valid = 1'b1; st_addr = 10'h100; st_ben = 4'hF; st_data = 32'h1;
    ld_valid = 1'b1; ld_addr = 10'h005;
    @(negedge clk);
    chk("fill0_st_ready", 256'(st_ready), 256'(1));
    chk("fill0_ld_ready", 256'(ld_ready), 256'(1));
    tick;
    st_addr = 10'h101; st_data = 32'h2;
    @(negedge clk);
    chk("fill1_st_ready", 256'(st_ready),  256'(1));
    chk("fill1_ld_ready", 256'(ld_ready),  256'(1));
    chk("fill1_rvalid",   256'(ld_rvalid), 256'(1));
    tick;
    st_valid = 1'b0;
    @(negedge clk);
    chk("full_st_ready", 256'(st_ready),   256'(0));
    chk("full_ld_ready", 256'(ld_ready),   256'(0));
    chk("full_store",    256'(bank_store), 256'(1));
    chk("full_waddr",    256'(bank_waddr), 256'(10'h100));
    tick;
    @(negedge clk);
    chk("pop_st_ready", 256'(st_ready),  256'(1));
    chk("pop_ld_ready", 256'(ld_ready),  256'(1));
    chk("pop_rvalid",   256'(ld_rvalid), 256'(0));
    tick;
    ld_valid = 1'b0;
    @(negedge clk);
    chk("tail_waddr",  256'(bank_waddr), 256'(10'h101));
    chk("tail_rvalid", 256'(ld_rvalid),  256'(1));
    tick;
    @(negedge clk);
    chk("tail_sb_empty", 256'(sb_empty), 256'(1));

    // Reset one cycle after a load accept with the buffer going full
    st_valid = 1'b1; st_addr = 10'h200; st_ben = 4'hF; st_data = 32'h5;
    tick;
    st_addr = 10'h201;
    ld_valid = 1'b1; ld_addr = 10'h005;
    @(negedge clk);
    chk("pre_rst_ld_ready", 256'(ld_ready), 256'(1));
    tick;
    rst = 1'b1;
    st_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("arst_rvalid",   256'(ld_rvalid), 256'(0));
    chk("arst_sb_empty", 256'(sb_empty),  256'(1));
    chk("arst_st_ready", 256'(st_ready),  256'(1));
    tick;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_we", 256'(bank_we),  256'(0));
      chk("post_rst_sb", 256'(sb_empty), 256'(1));
      tick;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
